// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, keeps one instruction-memory request
// in flight at a time, and registers the fetched word into the IF/ID boundary.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pcinc
);

    // state | meaning
    // IDLE  | first cycle out of reset, memory responses ignored
    // ISSUE | request for pc presented to memory
    // WAIT  | request accepted, waiting for the response
    // HOLD  | response captured during a stall, waiting for the stall to drop
    // DRAIN | request accepted on a stale path, response will be thrown away
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DRAIN} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] hold_instr, hold_n;
    logic        deliver;
    logic [31:0] deliver_word;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = redirect_pc & ~32'h3;
    assign imem_req     = (state == ISSUE);
    assign imem_addr    = pc;

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        hold_n       = hold_instr;
        deliver      = 1'b0;
        deliver_word = hold_instr;
        case (state)
            IDLE:  state_n = ISSUE;
            ISSUE: if (imem_ready) state_n = redirect ? DRAIN : WAIT;
            WAIT: begin
                if (imem_rvalid) begin
                    if (redirect) begin
                        state_n = ISSUE;
                    end else if (stall) begin
                        hold_n  = imem_rdata;
                        state_n = HOLD;
                    end else begin
                        deliver      = 1'b1;
                        deliver_word = imem_rdata;
                        state_n      = ISSUE;
                    end
                end else if (redirect) begin
                    state_n = DRAIN;
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_n = ISSUE;
                end else if (!stall) begin
                    deliver = 1'b1;
                    state_n = ISSUE;
                end
            end
            DRAIN: if (imem_rvalid) state_n = ISSUE;
            default: state_n = IDLE;
        endcase
        // A redirect always overrides the sequential increment.
        if (redirect)     pc_n = redirect_tgt;
        else if (deliver) pc_n = pc + 32'd4;
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            hold_instr <= 32'h0;
            if_valid   <= 1'b0;
            if_instr   <= 32'h0;
            if_pc      <= 32'h0;
            if_pcinc   <= 32'h0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            hold_instr <= hold_n;
            if (redirect) begin
                if_valid <= 1'b0;
            end else if (stall) begin
                if_valid <= if_valid;
            end else if (deliver) begin
                if_valid <= 1'b1;
                if_instr <= deliver_word;
                if_pc    <= pc;
                if_pcinc <= pc + 32'd4;
            end else begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus a randomized run
// against a transaction-level fetch model with a variable-latency memory.
module tb_pc_fetch_unit;
    localparam logic [31:0] RST = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr, if_pc, if_pcinc;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(.RESET_PC(RST)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pcinc(if_pcinc)
    );

    always #5 clk = ~clk;

    // Model: started = left reset idle, busy = accepted request awaiting reply,
    // stale = that reply belongs to an abandoned path, have = word parked by a stall.
    bit          m_started, m_busy, m_stale, m_have;
    logic [31:0] m_word, m_pc;
    logic        e_valid;
    logic [31:0] e_instr, e_pc, e_pcinc;

    task automatic model_reset();
        m_started = 0; m_busy = 0; m_stale = 0; m_have = 0;
        m_word = 0; m_pc = RST;
        e_valid = 0; e_instr = 0; e_pc = 0; e_pcinc = 0;
    endtask

    task automatic reset_cycle();
        reset = 1; stall = 0; redirect = 0; imem_ready = 0; imem_rvalid = 0;
        @(negedge clk);
        model_reset();
        #1;
    endtask

    task automatic cycle(input logic r, input logic [31:0] rp, input logic st,
                         input logic rdy, input logic rv, input logic [31:0] rd);
        bit          dlv;
        logic [31:0] w;
        reset = 0; redirect = r; redirect_pc = rp; stall = st;
        imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
        @(negedge clk);
        dlv = 0; w = 0;
        if (!m_started) begin
            m_started = 1;
        end else if (m_have) begin
            if (r) m_have = 0;
            else if (!st) begin dlv = 1; w = m_word; m_have = 0; end
        end else if (!m_busy) begin
            if (rdy) begin m_busy = 1; m_stale = r; end
        end else if (rv) begin
            m_busy = 0;
            if (!m_stale && !r) begin
                if (st) begin m_have = 1; m_word = rd; end
                else begin dlv = 1; w = rd; end
            end
            m_stale = 0;
        end else if (r) begin
            m_stale = 1;
        end
        if (r) e_valid = 0;
        else if (st) e_valid = e_valid;
        else if (dlv) begin
            e_valid = 1; e_instr = w; e_pc = m_pc; e_pcinc = m_pc + 32'd4;
        end else e_valid = 0;
        if (r) m_pc = {rp[31:2], 2'b00};
        else if (dlv) m_pc = m_pc + 32'd4;
        #1;
    endtask

    task automatic test_reset();
        reset_cycle();
        reset_cycle();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (imem_addr !== RST) begin errors++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RST); end
        checks++; if ({if_valid, if_instr, if_pc, if_pcinc} !== 97'h0) begin
            errors++; $display("FAIL reset_if got=%b %h %h %h exp=0", if_valid, if_instr, if_pc, if_pcinc);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] d;
        reset_cycle();
        cycle(0, 0, 0, 1, 0, 0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== RST) begin
            errors++; $display("FAIL zw_first got=%b %h exp=1 %h", imem_req, imem_addr, RST);
        end
        for (int k = 0; k < 6; k++) begin
            d = $urandom;
            cycle(0, 0, 0, 1, k[0], d);
            checks++; if (if_valid !== k[0]) begin
                errors++; $display("FAIL zw_valid k=%0d got=%b exp=%b", k, if_valid, k[0]);
            end
            if (k[0]) begin
                checks++; if (if_instr !== d || if_pc !== RST + 32'd4 * (k / 2) || if_pcinc !== if_pc + 32'd4) begin
                    errors++; $display("FAIL zw_deliver k=%0d got=%h %h %h exp=%h %h", k, if_instr, if_pc, if_pcinc, d, RST + 32'd4 * (k / 2));
                end
                checks++; if (imem_req !== 1'b1 || imem_addr !== RST + 32'd4 * (k / 2 + 1)) begin
                    errors++; $display("FAIL zw_addr k=%0d got=%b %h exp=1 %h", k, imem_req, imem_addr, RST + 32'd4 * (k / 2 + 1));
                end
            end
        end
    endtask

    task automatic test_stall_hold();
        reset_cycle();
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 1, 1, 1, 32'hDEADBEEF);
        for (int k = 0; k < 2; k++) begin
            checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_instr !== 32'h0) begin
                errors++; $display("FAIL stall_hold k=%0d got=%b %b %h exp=0 0 0", k, imem_req, if_valid, if_instr);
            end
            cycle(0, 0, 1, 1, 0, 0);
        end
        checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            errors++; $display("FAIL stall_hold3 got=%b %b exp=0 0", imem_req, if_valid);
        end
        cycle(0, 0, 0, 1, 0, 0);
        checks++; if (if_valid !== 1'b1 || if_instr !== 32'hDEADBEEF || if_pc !== RST || if_pcinc !== RST + 32'd4) begin
            errors++; $display("FAIL stall_release got=%b %h %h %h exp=1 deadbeef %h %h", if_valid, if_instr, if_pc, if_pcinc, RST, RST + 32'd4);
        end
        checks++; if (imem_req !== 1'b1 || imem_addr !== RST + 32'd4) begin
            errors++; $display("FAIL stall_next got=%b %h exp=1 %h", imem_req, imem_addr, RST + 32'd4);
        end
    endtask

    task automatic test_redirect_drain();
        cycle(0, 0, 0, 1, 0, 0);
        cycle(1, 32'h0000_1003, 0, 0, 0, 0);
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL drain_enter got=%b %b exp=0 0", if_valid, imem_req);
        end
        cycle(0, 0, 0, 0, 1, 32'h1111_1111);
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_1000) begin
            errors++; $display("FAIL drain_exit got=%b %b %h exp=0 1 00001000", if_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        cycle(1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_redir got=%b %h exp=1 fffffffc", imem_req, imem_addr);
        end
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 32'hCAFE_0001);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_pcinc !== 32'h0 || if_instr !== 32'hCAFE_0001) begin
            errors++; $display("FAIL wrap_deliver got=%b %h %h %h exp=1 cafe0001 fffffffc 0", if_valid, if_instr, if_pc, if_pcinc);
        end
        checks++; if (imem_addr !== 32'h0) begin
            errors++; $display("FAIL wrap_addr got=%h exp=0", imem_addr);
        end
    endtask

    task automatic test_redirect_wins();
        cycle(0, 0, 0, 1, 0, 0);
        cycle(1, 32'h0000_2002, 1, 0, 1, 32'h5555_AAAA);
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_2000 || if_instr !== 32'hCAFE_0001) begin
            errors++; $display("FAIL redir_wins got=%b %b %h %h exp=0 1 00002000 cafe0001", if_valid, imem_req, imem_addr, if_instr);
        end
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 32'h0BAD_F00D);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_2000 || if_instr !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL redir_resume got=%b %h %h exp=1 0badf00d 00002000", if_valid, if_instr, if_pc);
        end
    endtask

    task automatic test_reset_mid();
        cycle(0, 0, 0, 1, 0, 0);
        reset_cycle();
        checks++; if ({imem_req, if_valid, if_instr, if_pc, if_pcinc} !== 98'h0 || imem_addr !== RST) begin
            errors++; $display("FAIL rmid_reset got=%b %b %h %h %h %h", imem_req, if_valid, if_instr, if_pc, if_pcinc, imem_addr);
        end
        cycle(0, 0, 0, 1, 1, 32'h7777_7777);
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RST) begin
            errors++; $display("FAIL rmid_idle got=%b %b %h exp=0 1 %h", if_valid, imem_req, imem_addr, RST);
        end
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 1, 32'h1234_5678);
        checks++; if (if_valid !== 1'b1 || if_instr !== 32'h1234_5678 || if_pc !== RST) begin
            errors++; $display("FAIL rmid_first got=%b %h %h exp=1 12345678 %h", if_valid, if_instr, if_pc, RST);
        end
    endtask

    task automatic test_random();
        bit          mem_out, rv, acc;
        int          dly;
        logic [31:0] rd;
        int          bad;
        mem_out = 0; dly = 0; bad = 0;
        reset_cycle();
        for (int n = 0; n < 600; n++) begin
            rv = 0;
            rd = $urandom;
            if (mem_out) begin
                if (dly == 0) rv = 1;
                else dly--;
            end else begin
                rv = ($urandom % 8) == 0;
            end
            acc = imem_req && 1'b1;
            begin
                logic rdy, st, r;
                rdy = ($urandom % 4) != 0;
                st  = ($urandom % 4) == 0;
                r   = ($urandom % 12) == 0;
                acc = imem_req && rdy;
                cycle(r, $urandom, st, rdy, rv, rd);
            end
            if (rv && mem_out) mem_out = 0;
            if (acc) begin mem_out = 1; dly = $urandom % 3; end
            checks++;
            if (imem_req !== (m_started && !m_busy && !m_have) || imem_addr !== m_pc ||
                if_valid !== e_valid || (e_valid && (if_instr !== e_instr || if_pc !== e_pc || if_pcinc !== e_pcinc))) begin
                errors++;
                if (bad < 5) $display("FAIL rand n=%0d got=%b %h %b %h %h %h exp=%b %h %b %h %h %h", n,
                    imem_req, imem_addr, if_valid, if_instr, if_pc, if_pcinc,
                    (m_started && !m_busy && !m_have), m_pc, e_valid, e_instr, e_pc, e_pcinc);
                bad++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_zero_wait();
        test_stall_hold();
        test_redirect_drain();
        test_wrap();
        test_redirect_wins();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
